// File: rtl/colour_sensor_emulator_pkg.sv
// colour_sensor_pkg: filter/scale encodings, multipliers and FSM states shared by sensor and driver sides
package colour_sensor_pkg;
    localparam logic [1:0] RED   = 2'b00;
    localparam logic [1:0] BLUE  = 2'b01;
    localparam logic [1:0] CLEAR = 2'b10;
    localparam logic [1:0] GREEN = 2'b11;
    localparam logic [1:0] SCL_OFF = 2'b00;
    localparam logic [1:0] SCL_2   = 2'b01;
    localparam logic [1:0] SCL_20  = 2'b10;
    localparam logic [1:0] SCL_100 = 2'b11;
    localparam logic [5:0] MULT_100 = 6'd1;
    localparam logic [5:0] MULT_20  = 6'd5;
    localparam logic [5:0] MULT_2   = 6'd50;
    typedef enum logic [1:0] {ST_OFF, ST_SETTLE, ST_RUN} state_e;
    function automatic logic [5:0] scale_mult(input logic [1:0] s);
        return s == SCL_100 ? MULT_100 : s == SCL_20 ? MULT_20 : s == SCL_2 ? MULT_2 : 6'd0;
    endfunction
endpackage

// File: rtl/colour_sensor_emulator_if.sv
// colour_sensor_emulator_if: base-period register write bus
interface colour_sensor_emulator_if;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    modport master (output cfg_we, cfg_addr, cfg_wdata);
    modport slave  (input cfg_we, cfg_addr, cfg_wdata);
endinterface

// File: rtl/colour_sensor_emulator_sync2.sv
// sync2: two-flop synchronizer with synchronous active-low clear
module sync2 (
    input  logic clk50,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d, sync_q, sync_d;
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end
    assign q = sync_q;
endmodule

// File: rtl/colour_sensor_emulator.sv
// colour_sensor_emulator: TCS3200-style sensor stand-in driving a scaled, per-filter square wave on OUT
module colour_sensor_emulator
    import colour_sensor_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int SETTLE_CYC = 64,
    parameter int RST_RED    = 1000,
    parameter int RST_BLUE   = 1200,
    parameter int RST_CLEAR  = 400,
    parameter int RST_GREEN  = 1500
) (
    input  logic                     clk50,
    input  logic                     rst_n,
    input  logic                     S0,
    input  logic                     S1,
    input  logic                     S2,
    input  logic                     S3,
    colour_sensor_emulator_if.slave  cfg,
    output logic                     OUT,
    output logic                     out_active,
    output logic [15:0]              pulse_count
);
    if (CLK_HZ <= 0) begin : g_bad_clk
        $error("CLK_HZ must be positive");
    end
    logic [3:0] s_raw, s_sync, s_prev_q, s_prev_d;
    logic [3:0][15:0] base_q, base_d;
    state_e state_q, state_d;
    logic out_q, out_d, change, pwr_off;
    logic [15:0] pulse_q, pulse_d, settle_q, settle_d, base, eff_base;
    logic [21:0] hcnt_q, hcnt_d, high_q, high_d, low_q, low_d, period, high, low;
    assign s_raw = {S0, S1, S2, S3};
    for (genvar i = 0; i < 4; i++) begin : g_sync
        sync2 u_sync (.clk50(clk50), .rst_n(rst_n), .d(s_raw[i]), .q(s_sync[i]));
    end
    always_comb begin
        base_d = base_q;
        if (cfg.cfg_we) base_d[cfg.cfg_addr] = cfg.cfg_wdata;
        s_prev_d = s_sync;
        change   = s_sync != s_prev_q;
        pwr_off  = s_sync[3:2] == SCL_OFF;
        base     = base_q[s_sync[1:0]];
        eff_base = base < 16'd2 ? 16'd2 : base;
        period   = 22'(eff_base) * 22'(scale_mult(s_sync[3:2]));
        high     = period >> 1;
        low      = period - high;
        state_d  = state_q;
        out_d    = out_q;
        pulse_d  = pulse_q;
        settle_d = settle_q;
        hcnt_d   = hcnt_q;
        high_d   = high_q;
        low_d    = low_q;
        case (state_q)
            ST_OFF: begin
                out_d   = 1'b0;
                pulse_d = 16'd0;
                if (!pwr_off) begin
                    state_d  = ST_SETTLE;
                    settle_d = 16'd0;
                end
            end
            ST_SETTLE: begin
                if (pwr_off) state_d = ST_OFF;
                else if (change) settle_d = 16'd0;
                else if (settle_q == 16'(SETTLE_CYC - 1)) begin
                    state_d = ST_RUN;
                    out_d   = 1'b1;
                    pulse_d = 16'd1;
                    hcnt_d  = 22'd0;
                    high_d  = high;
                    low_d   = low;
                end else settle_d = settle_q + 16'd1;
            end
            ST_RUN: begin
                // a pin change beats a period boundary landing on the same cycle
                if (change) begin
                    state_d  = pwr_off ? ST_OFF : ST_SETTLE;
                    out_d    = 1'b0;
                    pulse_d  = 16'd0;
                    settle_d = 16'd0;
                end else if (out_q) begin
                    out_d  = hcnt_q != high_q - 22'd1;
                    hcnt_d = out_d ? hcnt_q + 22'd1 : 22'd0;
                end else if (hcnt_q == low_q - 22'd1) begin
                    out_d   = 1'b1;
                    hcnt_d  = 22'd0;
                    high_d  = high;
                    low_d   = low;
                    pulse_d = pulse_q == 16'hFFFF ? pulse_q : pulse_q + 16'd1;
                end else hcnt_d = hcnt_q + 22'd1;
            end
            default: state_d = ST_OFF;
        endcase
    end
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            out_q    <= 1'b0;
            pulse_q  <= 16'd0;
            settle_q <= 16'd0;
            hcnt_q   <= 22'd0;
            high_q   <= 22'd0;
            low_q    <= 22'd0;
            s_prev_q <= 4'd0;
            base_q   <= {16'(RST_GREEN), 16'(RST_CLEAR), 16'(RST_BLUE), 16'(RST_RED)};
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            pulse_q  <= pulse_d;
            settle_q <= settle_d;
            hcnt_q   <= hcnt_d;
            high_q   <= high_d;
            low_q    <= low_d;
            s_prev_q <= s_prev_d;
            base_q   <= base_d;
        end
    end
    assign OUT         = out_q;
    assign out_active  = state_q == ST_RUN;
    assign pulse_count = pulse_q;
endmodule

// File: tb/tb_colour_sensor_emulator.sv
// tb_colour_sensor_emulator: directed tests of settle timing, period decode, live writes and reset
module tb_colour_sensor_emulator;
    import colour_sensor_pkg::*;
    logic clk50, rst_n, S0, S1, S2, S3, OUT, out_active;
    logic [15:0] pulse_count;
    int tests_run = 0, tests_failed = 0;
    colour_sensor_emulator_if cfg_if ();
    colour_sensor_emulator dut (
        .clk50(clk50), .rst_n(rst_n), .S0(S0), .S1(S1), .S2(S2), .S3(S3), .cfg(cfg_if),
        .OUT(OUT), .out_active(out_active), .pulse_count(pulse_count)
    );
    initial begin
        clk50 = 1'b0;
        forever #10 clk50 = ~clk50;
    end
    task automatic cyc(input int n);
        repeat (n) @(negedge clk50);
    endtask
    task automatic set_s(input logic [3:0] v);
        {S0, S1, S2, S3} = v;
    endtask
    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        cfg_if.cfg_we = 1'b1;
        cfg_if.cfg_addr = a;
        cfg_if.cfg_wdata = d;
        @(negedge clk50);
        cfg_if.cfg_we = 1'b0;
    endtask
    task automatic wait_out(input logic v, input int limit, output int n);
        n = 0;
        while (OUT !== v && n < limit) begin
            @(negedge clk50);
            n++;
        end
    endtask
    task automatic period_meas(output int hi, output int lo);
        int t;
        wait_out(1'b0, 20000, t);
        wait_out(1'b1, 20000, t);
        wait_out(1'b0, 20000, hi);
        wait_out(1'b1, 20000, lo);
    endtask
    task automatic test_reset;
        rst_n = 1'b0;
        set_s(4'b0000);
        cfg_if.cfg_we = 1'b0; cfg_if.cfg_addr = 2'd0; cfg_if.cfg_wdata = 16'd0;
        cyc(2);
        tests_run++; if (OUT !== 1'b0) begin tests_failed++; $display("FAIL reset_out: got %b want 0", OUT); end
        tests_run++; if (out_active !== 1'b0) begin tests_failed++; $display("FAIL reset_active: got %b want 0", out_active); end
        tests_run++; if (pulse_count !== 16'd0) begin tests_failed++; $display("FAIL reset_pulse: got %0d want 0", pulse_count); end
        tests_run++; if (dut.state_q !== ST_OFF) begin tests_failed++; $display("FAIL reset_state: got %0d want OFF", dut.state_q); end
        tests_run++; if (dut.base_q !== {16'd1500, 16'd400, 16'd1200, 16'd1000}) begin tests_failed++; $display("FAIL reset_bases: got %h want 05dc019004b003e8", dut.base_q); end
    endtask
    task automatic test_default_red;
        int hi, lo;
        set_s(4'b1100);
        cyc(1);
        rst_n = 1'b1;
        cyc(66);
        tests_run++; if (OUT !== 1'b0 || out_active !== 1'b0) begin tests_failed++; $display("FAIL red_settle_66: OUT=%b active=%b want 0 0", OUT, out_active); end
        cyc(1);
        tests_run++; if (OUT !== 1'b1 || out_active !== 1'b1 || pulse_count !== 16'd1) begin tests_failed++; $display("FAIL red_first_run: OUT=%b active=%b pulse=%0d want 1 1 1", OUT, out_active, pulse_count); end
        wait_out(1'b0, 20000, hi);
        wait_out(1'b1, 20000, lo);
        tests_run++; if (hi !== 500 || lo !== 500) begin tests_failed++; $display("FAIL red_period: high=%0d low=%0d want 500 500", hi, lo); end
        tests_run++; if (pulse_count !== 16'd2) begin tests_failed++; $display("FAIL red_pulse2: got %0d want 2", pulse_count); end
        cyc(3000);
        tests_run++; if (OUT !== 1'b1 || pulse_count !== 16'd5) begin tests_failed++; $display("FAIL red_pulse5: OUT=%b pulse=%0d want 1 5", OUT, pulse_count); end
    endtask
    task automatic test_green_scaling;
        int hi, lo;
        set_s(4'b1011);
        cyc(67);
        tests_run++; if (OUT !== 1'b1 || out_active !== 1'b1) begin tests_failed++; $display("FAIL green20_start: OUT=%b active=%b want 1 1", OUT, out_active); end
        wait_out(1'b0, 20000, hi);
        wait_out(1'b1, 20000, lo);
        tests_run++; if (hi !== 3750 || lo !== 3750) begin tests_failed++; $display("FAIL green20_period: high=%0d low=%0d want 3750 3750", hi, lo); end
        // pin change and base write land on the same cycle; the new base is used at settle end
        set_s(4'b0111);
        cfg_write(GREEN, 16'd10);
        cyc(66);
        tests_run++; if (OUT !== 1'b1 || pulse_count !== 16'd1) begin tests_failed++; $display("FAIL green2_start: OUT=%b pulse=%0d want 1 1", OUT, pulse_count); end
        wait_out(1'b0, 20000, hi);
        wait_out(1'b1, 20000, lo);
        tests_run++; if (hi !== 250 || lo !== 250) begin tests_failed++; $display("FAIL green2_period: high=%0d low=%0d want 250 250", hi, lo); end
    endtask
    task automatic test_odd_period;
        int hi, lo;
        cfg_write(CLEAR, 16'd7);
        set_s(4'b1110);
        cyc(67);
        tests_run++; if (OUT !== 1'b1) begin tests_failed++; $display("FAIL clear_start: OUT=%b want 1", OUT); end
        wait_out(1'b0, 20000, hi);
        wait_out(1'b1, 20000, lo);
        tests_run++; if (hi !== 3 || lo !== 4) begin tests_failed++; $display("FAIL odd_period7: high=%0d low=%0d want 3 4", hi, lo); end
        cfg_write(CLEAR, 16'd1);
        cyc(20);
        period_meas(hi, lo);
        tests_run++; if (hi !== 1 || lo !== 1) begin tests_failed++; $display("FAIL base1_clamp: high=%0d low=%0d want 1 1", hi, lo); end
        cfg_write(CLEAR, 16'd0);
        cyc(20);
        period_meas(hi, lo);
        tests_run++; if (hi !== 1 || lo !== 1) begin tests_failed++; $display("FAIL base0_clamp: high=%0d low=%0d want 1 1", hi, lo); end
    endtask
    task automatic test_filter_change;
        int hi, lo, bad;
        set_s(4'b1100);
        cyc(67);
        tests_run++; if (OUT !== 1'b1) begin tests_failed++; $display("FAIL fc_red_start: OUT=%b want 1", OUT); end
        cyc(100);
        set_s(4'b1101);
        cyc(2);
        tests_run++; if (OUT !== 1'b1) begin tests_failed++; $display("FAIL fc_edge2: OUT=%b want 1", OUT); end
        cyc(1);
        tests_run++; if (OUT !== 1'b0 || out_active !== 1'b0 || pulse_count !== 16'd0) begin tests_failed++; $display("FAIL fc_edge3: OUT=%b active=%b pulse=%0d want 0 0 0", OUT, out_active, pulse_count); end
        bad = 0;
        for (int i = 0; i < 63; i++) begin
            cyc(1);
            if (OUT !== 1'b0 || out_active !== 1'b0 || pulse_count !== 16'd0) bad++;
        end
        tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL fc_settle_hold: %0d bad cycles want 0", bad); end
        cyc(1);
        tests_run++; if (OUT !== 1'b1 || out_active !== 1'b1) begin tests_failed++; $display("FAIL fc_restart: OUT=%b active=%b want 1 1", OUT, out_active); end
        wait_out(1'b0, 20000, hi);
        wait_out(1'b1, 20000, lo);
        tests_run++; if (hi !== 600 || lo !== 600) begin tests_failed++; $display("FAIL fc_blue_period: high=%0d low=%0d want 600 600", hi, lo); end
    endtask
    task automatic test_live_write;
        int h1, l1, h2, l2;
        set_s(4'b1100);
        cyc(67);
        tests_run++; if (OUT !== 1'b1) begin tests_failed++; $display("FAIL lw_start: OUT=%b want 1", OUT); end
        cyc(100);
        cfg_write(RED, 16'd200);
        tests_run++; if (dut.base_q[0] !== 16'd200) begin tests_failed++; $display("FAIL lw_reg: got %0d want 200", dut.base_q[0]); end
        wait_out(1'b0, 20000, h1);
        wait_out(1'b1, 20000, l1);
        wait_out(1'b0, 20000, h2);
        wait_out(1'b1, 20000, l2);
        tests_run++; if (h1 !== 399 || l1 !== 500) begin tests_failed++; $display("FAIL lw_current: high=%0d low=%0d want 399 500", h1, l1); end
        tests_run++; if (h2 !== 100 || l2 !== 100) begin tests_failed++; $display("FAIL lw_next: high=%0d low=%0d want 100 100", h2, l2); end
        cfg_write(BLUE, 16'd50);
        period_meas(h1, l1);
        tests_run++; if (h1 !== 100 || l1 !== 100) begin tests_failed++; $display("FAIL inactive_write: high=%0d low=%0d want 100 100", h1, l1); end
    endtask
    task automatic test_powerdown;
        set_s(4'b0000);
        cyc(3);
        tests_run++; if (OUT !== 1'b0 || out_active !== 1'b0 || pulse_count !== 16'd0) begin tests_failed++; $display("FAIL pd_outputs: OUT=%b active=%b pulse=%0d want 0 0 0", OUT, out_active, pulse_count); end
        tests_run++; if (dut.state_q !== ST_OFF) begin tests_failed++; $display("FAIL pd_state: got %0d want OFF", dut.state_q); end
        cyc(100);
        tests_run++; if (OUT !== 1'b0 || dut.state_q !== ST_OFF) begin tests_failed++; $display("FAIL pd_stay: OUT=%b state=%0d want 0 OFF", OUT, dut.state_q); end
    endtask
    task automatic test_reset_mid_run;
        set_s(4'b1100);
        cyc(67);
        cyc(50);
        tests_run++; if (OUT !== 1'b1 || pulse_count !== 16'd1) begin tests_failed++; $display("FAIL rm_pre: OUT=%b pulse=%0d want 1 1", OUT, pulse_count); end
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        tests_run++; if (OUT !== 1'b0 || pulse_count !== 16'd0 || out_active !== 1'b0) begin tests_failed++; $display("FAIL rm_outputs: OUT=%b active=%b pulse=%0d want 0 0 0", OUT, out_active, pulse_count); end
        tests_run++; if (dut.base_q[0] !== 16'd1000) begin tests_failed++; $display("FAIL rm_red_base: got %0d want 1000", dut.base_q[0]); end
        cyc(66);
        tests_run++; if (OUT !== 1'b0) begin tests_failed++; $display("FAIL rm_settle: OUT=%b want 0", OUT); end
        cyc(1);
        tests_run++; if (OUT !== 1'b1 || pulse_count !== 16'd1) begin tests_failed++; $display("FAIL rm_restart: OUT=%b pulse=%0d want 1 1", OUT, pulse_count); end
    endtask
    initial begin
        test_reset;
        test_default_red;
        test_green_scaling;
        test_odd_period;
        test_filter_change;
        test_live_write;
        test_powerdown;
        test_reset_mid_run;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
